// File: rtl/execution_controller_if.sv
// execution_controller_if: tick, button, breakpoint and status signals between board glue and the execution controller
interface execution_controller_if #(
  parameter int PC_WIDTH = 8,
  parameter int COUNT_WIDTH = 8
);
  logic tick;
  logic run_btn;
  logic step_btn;
  logic halt_btn;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] bp_addr;
  logic bp_enable;
  logic cpu_enable;
  logic [1:0] state;
  logic bp_hit;
  logic [COUNT_WIDTH-1:0] retired_count;
  modport master (
    output tick, run_btn, step_btn, halt_btn, pc, bp_addr, bp_enable,
    input cpu_enable, state, bp_hit, retired_count
  );
  modport slave (
    input tick, run_btn, step_btn, halt_btn, pc, bp_addr, bp_enable,
    output cpu_enable, state, bp_hit, retired_count
  );
endinterface

// File: rtl/execution_controller.sv
// execution_controller: run/step/halt sequencing, PC breakpoint and retired-instruction count for the core
module execution_controller #(
  parameter int PC_WIDTH = 8,
  parameter int COUNT_WIDTH = 8
) (
  input logic clock,
  input logic clear,
  execution_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALT = 2'b11} state_t;
  state_t state_q, state_d;
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, ev;
  logic en_q, en_d, bp_hit_q, bp_hit_d, skip_q, skip_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [PC_WIDTH-1:0] pc, bp_addr;
  logic halt_ev, run_ev, step_ev, tick_ok, bp_match;
  assign pc = bus.pc;
  assign bp_addr = bus.bp_addr;
  always_comb begin
    sync1_d = {bus.halt_btn, bus.step_btn, bus.run_btn};
    sync2_d = sync1_q;
    prev_d = sync2_q;
    ev = sync2_q & ~prev_q;
    halt_ev = ev[2];
    run_ev = ev[0] & ~ev[2];
    step_ev = ev[1] & ~ev[0] & ~ev[2];
    // a tick landing on an enable cycle is dropped so enables never abut
    tick_ok = bus.tick & ~en_q;
    bp_match = bus.bp_enable & (pc == bp_addr) & ~skip_q;
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q <= '0;
      en_q <= 1'b0;
      bp_hit_q <= 1'b0;
      skip_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q <= prev_d;
      en_q <= en_d;
      bp_hit_q <= bp_hit_d;
      skip_q <= skip_d;
      count_q <= count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = run_ev ? RUN : step_ev ? STEP : IDLE;
      RUN: state_d = (halt_ev || (tick_ok && bp_match)) ? HALT : RUN;
      STEP: state_d = (halt_ev || tick_ok) ? HALT : STEP;
      HALT: state_d = run_ev ? RUN : step_ev ? STEP : HALT;
    endcase
  end
  always_comb begin
    en_d = ~halt_ev & tick_ok & ((state_q == RUN && !bp_match) || state_q == STEP);
    bp_hit_d = (state_q == RUN && !halt_ev && tick_ok && bp_match) ? 1'b1 :
               (state_q == RUN || (state_q == HALT && (run_ev || step_ev))) ? 1'b0 : bp_hit_q;
    // resuming from a breakpoint must execute the trapped instruction once
    skip_d = (state_q == HALT && run_ev) ? 1'b1 : (state_q == RUN && en_d) ? 1'b0 : skip_q;
    count_d = count_q + COUNT_WIDTH'(en_q);
  end
  assign bus.cpu_enable = en_q;
  assign bus.state = state_q;
  assign bus.bp_hit = bp_hit_q;
  assign bus.retired_count = count_q;
endmodule
